// File: rtl/cache_mem_bridge_if.sv
// Buses around cache_mem_bridge: the cache-side rd/wr/ret bus and the SRAM-like memory bus.
// On each bus the master drives the request and the slave drives the ready/response.

interface cache_bus_if #(
  parameter int LINE_WORDS = 4
);
  logic                     rd_req;
  logic [2:0]               rd_type;
  logic [31:0]              rd_addr;
  logic                     rd_rdy;
  logic                     ret_valid;
  logic                     ret_last;
  logic [31:0]              ret_data;
  logic                     wr_req;
  logic [2:0]               wr_type;
  logic [31:0]              wr_addr;
  logic [3:0]               wr_wstrb;
  logic [LINE_WORDS*32-1:0] wr_data;
  logic                     wr_rdy;

  modport master (
    output rd_req, rd_type, rd_addr,
    output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );

  modport slave (
    input  rd_req, rd_type, rd_addr,
    input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );
endinterface

interface mem_bus_if;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/cache_mem_bridge.sv
// Bridge between one cache's refill/write-back port and an SRAM-like single-beat memory bus.
// One request in flight at a time; writes are captured whole, then drained beat by beat.
//
// state | meaning
// IDLE  | ready for a new request; writes take priority over reads
// WRITE | draining the captured write, one beat per addr_ok
// READ  | issuing read beats, returning each word on data_ok

module cache_mem_bridge #(
  parameter int LINE_WORDS = 4
) (
  input  logic       clk,
  input  logic       reset,
  cache_bus_if.slave cache,
  mem_bus_if.master  mem
);

  localparam int              CW         = $clog2(LINE_WORDS) + 1;
  localparam int              IW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [2:0]      TYPE_LINE  = 3'b100;
  localparam logic [CW-1:0]   LINE_BEATS = CW'(LINE_WORDS);
  localparam logic [31:0]     LINE_MASK  = ~(32'(LINE_WORDS * 4) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] issued;
  logic [CW-1:0] done;
  logic [31:0]   addr_q;
  logic [2:0]    type_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   line_q [LINE_WORDS];

  logic          is_line;
  logic          active;
  logic          issue;
  logic          last_resp;
  logic [CW-1:0] beats;
  logic [IW-1:0] beat_idx;
  logic [31:0]   line_base;

  assign is_line   = (type_q == TYPE_LINE);
  assign beats     = is_line ? LINE_BEATS : CW'(1);
  assign active    = (state == WRITE) || (state == READ);
  assign beat_idx  = issued[IW-1:0];
  assign line_base = addr_q & LINE_MASK;

  // All memory-side request fields come from registers only, so they cannot move while addr_ok is low.
  assign mem.mem_req   = active && (issued < beats);
  assign mem.mem_wr    = (state == WRITE);
  assign mem.mem_size  = is_line ? 2'd2 : type_q[1:0];
  assign mem.mem_addr  = is_line ? (line_base + (32'(issued) << 2)) : addr_q;
  assign mem.mem_wstrb = is_line ? 4'hf : wstrb_q;
  assign mem.mem_wdata = line_q[beat_idx];

  assign issue     = mem.mem_req && mem.mem_addr_ok;
  assign last_resp = mem.mem_data_ok && (done == beats - CW'(1));

  assign cache.wr_rdy    = !reset && (state == IDLE);
  assign cache.rd_rdy    = !reset && (state == IDLE) && !cache.wr_req;
  assign cache.ret_valid = (state == READ) && mem.mem_data_ok;
  assign cache.ret_last  = cache.ret_valid && (done == beats - CW'(1));
  assign cache.ret_data  = mem.mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      issued  <= '0;
      done    <= '0;
      addr_q  <= '0;
      type_q  <= '0;
      wstrb_q <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          issued <= '0;
          done   <= '0;
          if (cache.wr_req) begin
            addr_q  <= cache.wr_addr;
            type_q  <= cache.wr_type;
            wstrb_q <= cache.wr_wstrb;
            for (int i = 0; i < LINE_WORDS; i++) begin
              line_q[i] <= cache.wr_data[i*32 +: 32];
            end
            state <= WRITE;
          end else if (cache.rd_req) begin
            addr_q  <= cache.rd_addr;
            type_q  <= cache.rd_type;
            wstrb_q <= 4'h0;
            state   <= READ;
          end
        end
        WRITE, READ: begin
          if (issue) begin
            issued <= issued + CW'(1);
          end
          // The final response ends the transaction; stray responses after that land in IDLE.
          if (last_resp) begin
            state  <= IDLE;
            issued <= '0;
            done   <= '0;
          end else if (mem.mem_data_ok) begin
            done <= done + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          issued <= '0;
          done   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_mem_bridge.md
Name: cache_mem_bridge

Overview:
Memory-side bridge directly downstream of one cache instance. It accepts the cache's line-refill and write-back requests, and its uncached single-word requests, on the cache's rd_*/wr_* interface. It converts each request into a sequence of single-beat transactions on the SRAM-like req/addr_ok/data_ok bus, and returns refill words to the cache one per ret_valid. A write is captured whole into an internal line buffer in the accepting cycle, then drained.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line; wr_data width is LINE_WORDS*32. Beat counters are clog2(LINE_WORDS)+1 bits.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rd_req  in  1  cache read request
rd_type  in  3  000 byte, 001 half, 010 word, 100 line
rd_addr  in  32  read address; line-aligned when rd_type=100
rd_rdy  out  1  bridge can accept read this cycle
ret_valid  out  1  one returned read word valid
ret_last  out  1  final returned word of the request
ret_data  out  32  returned word
wr_req  in  1  cache write request (cache asserts only while wr_rdy=1)
wr_type  in  3  encoding as rd_type
wr_addr  in  32  write address
wr_wstrb  in  4  byte strobes for non-line writes
wr_data  in  LINE_WORDS*32  line data; word i = bits [32i+31:32i]
wr_rdy  out  1  bridge can accept write this cycle
mem_req  out  1  memory request valid
mem_wr  out  1  1 write, 0 read
mem_size  out  2  0 byte, 1 half, 2 word
mem_addr  out  32  beat address
mem_wstrb  out  4  write strobes
mem_wdata  out  32  write data
mem_addr_ok  in  1  address accepted
mem_data_ok  in  1  read data valid / write acknowledged, in order
mem_rdata  in  32  read data

Behaviour:
- Reset values: state IDLE, all counters 0, mem_req=0, mem_wr=0, ret_valid=0, ret_last=0. rd_rdy and wr_rdy are 0 during reset, then 1 in IDLE.
- States: IDLE, WRITE, READ.
- wr_rdy = IDLE. wr_rdy must not depend on wr_req.
- rd_rdy = IDLE && !wr_req. When both requests arrive in the same cycle, the write wins and the read is retried after the drain.
- Accept write on wr_req && wr_rdy. Capture addr, type, wstrb and all of wr_data. Go to WRITE.
- Accept read on rd_req && rd_rdy. Capture addr and type. Go to READ.
- Beat count: LINE_WORDS if type=100, else 1.
- Line beat k: mem_addr = {addr[31:4], 4'b0} + 4k, mem_size=2, mem_wstrb=4'hf, mem_wdata = word k.
- Single beat: mem_addr = addr, mem_size = type[1:0], mem_wstrb = captured wstrb.
- Counter issued increments on mem_req && mem_addr_ok. mem_req = (WRITE||READ) && issued < beats.
- mem_addr, mem_wr, mem_size, mem_wstrb and mem_wdata stay stable while mem_req && !mem_addr_ok.
- Beats issue back-to-back: the next address may be presented in the cycle after addr_ok, before any data_ok.
- Counter done increments on mem_data_ok while in WRITE or READ. addr_ok and data_ok in the same cycle are both counted.
- READ: ret_valid = mem_data_ok and ret_data = mem_rdata, combinational with zero latency. ret_last = ret_valid && done == beats-1. For a single beat, ret_last is asserted together with ret_valid.
- Termination: when done reaches beats, next state is IDLE. A new request is accepted the cycle after return to IDLE.
- No new request is accepted while WRITE or READ is active. One transaction is in flight at a time.
- mem_data_ok in IDLE is ignored.
- Reset mid-operation: state and counters clear immediately. In-flight memory responses arriving after reset release are ignored.

Test Plan:
- Line read rd_addr=0x1c000040, addr_ok always 1, data_ok one cycle after each addr_ok, rdata = A0..A3 -> mem_addr 0x40,0x44,0x48,0x4c on consecutive cycles; four ret_valid with ret_data A0..A3; ret_last only on A3; rd_rdy high again the cycle after.
- Simultaneous wr_req (line, 0x00008000, data W0..W3) and rd_req (line, 0x1c000040) -> write accepted, rd_rdy=0. Four writes issue with mem_wstrb=f and wdata W0..W3. After 4 data_ok, return to IDLE, then the read is accepted.
- Uncached word read rd_type=010, addr 0xbfaf8004 -> one beat, mem_size=2; ret_valid and ret_last asserted in the same cycle.
- Byte write wr_type=000, addr 0x103, wstrb=1000 -> one beat, mem_size=0, mem_wstrb=1000, addr 0x103.
- addr_ok held 0 for 3 cycles on beat 2 of a line read -> mem_addr held at 0x48 and stable; data order unchanged.
- Assert reset after 2 of 4 read beats returned -> next cycle IDLE, mem_req=0, ret_valid=0; a stray data_ok after release produces no ret_valid.
